ifetch_unit: RTL and testbench



---
 rtl/cpu_pipe_pkg.sv | 15 +
 rtl/ifq_fifo.sv | 76 +++++++
 rtl/ifetch_unit.sv | 95 +++++++++
 tb/tb_ifetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the CPU front-end pipeline stages.
// Holds the fetch-entry layout and the program-memory timing assumptions.
package cpu_pipe_pkg;

    localparam int IMEM_LATENCY  = 1;
    localparam int IF_WIDTH      = 32;
    localparam int IF_ADDR_WIDTH = 12;
    localparam int RESET_PC_DEF  = 0;

    typedef struct packed {
        logic [IF_WIDTH-1:0]      instr;
        logic [IF_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue: DEPTH-entry FIFO with synchronous flush. Head is read combinationally.
// Latency: one cycle from push to visible head. No backpressure: the producer must never push into a full queue.
module ifq_fifo import cpu_pipe_pkg::*; #(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: PC generation, 1-cycle imem access, PC-tagged instruction queue toward decode.
// Latency: request at t, dec_valid at t+2. Decode stalls throttle fetch by credit; a redirect flushes everything in flight.
module ifetch_unit import cpu_pipe_pkg::*; #(
    parameter int                    WIDTH      = IF_WIDTH,
    parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic [WIDTH-1:0]      imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [WIDTH-1:0]      dec_instr,
    output logic [ADDR_WIDTH-1:0] dec_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0]      instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        occ;
    logic                  pop;
    logic                  push;
    entry_t                push_dat;
    entry_t                head_dat;

    assign dec_valid = (count != '0) && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    assign push      = inflight_q && !redirect_valid;

    // Credit: slots already used or promised, after this cycle's pop, must leave room.
    assign occ      = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign imem_req = !reset && !redirect_valid && (occ < (CNT_W+1)'(DEPTH));

    assign push_dat  = '{instr: imem_rdata, pc: issued_pc_q};
    assign imem_addr = pc_q;
    assign dec_instr = head_dat.instr;
    assign dec_pc    = head_dat.pc;

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = imem_req;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d        = pc_q + ADDR_WIDTH'(1);
            issued_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    ifq_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_ifq (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (!imem_req && !redirect_valid) |=> $stable(imem_addr));
    a_resp_tracked: assert property (@(posedge clk) disable iff (reset)
        imem_req |-> ##IMEM_LATENCY inflight_q);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory model returns 0x1000_0000 + addr; a scoreboard queue holds expected decode deliveries.
module tb_ifetch_unit;

    localparam int W  = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic [W-1:0]  imem_rdata = '0;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [W-1:0]  dec_instr;
    logic [AW-1:0] dec_pc;

    typedef struct {
        logic [AW-1:0] pc;
        logic [W-1:0]  instr;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    ifetch_unit #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .DEPTH      (2),
        .RESET_PC   (12'h000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h1000_0000 + {20'h0, imem_addr};
    end

    // Every accepted decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && !reset && dec_valid && dec_ready) begin
            checks++;
            if (q_exp.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: delivered pc=%h with nothing expected", dec_pc);
            end else begin
                mon_e = q_exp.pop_front();
                if (dec_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL sb_pc: got %h expected %h", dec_pc, mon_e.pc);
                end
                checks++;
                if (dec_instr !== mon_e.instr) begin
                    errors++;
                    $display("FAIL sb_instr: got %h expected %h", dec_instr, mon_e.instr);
                end
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h1000_0000 + {20'h0, pc};
        q_exp.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle out of reset).
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        q_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dec_valid); end
        checks++;
        if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", dec_instr); end
        checks++;
        if (dec_pc !== 12'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", dec_pc); end
        checks++;
        if (imem_addr !== 12'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) push_exp(12'(i));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== c[AW-1:0]) begin
                errors++;
                $display("FAIL stream_req c%0d: req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, c[AW-1:0]);
            end
            checks++;
            if (dec_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL stream_valid c%0d: got %b expected %b", c, dec_valid, (c >= 2));
            end
            next_cycle();
        end
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left expected 0", q_exp.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(12'(i));
        for (int c = 0; c < 14; c++) begin
            dec_ready = !(c >= 2 && c <= 7);
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== 12'h0 || dec_instr !== 32'h1000_0000) begin
                    errors++;
                    $display("FAIL stall_head c%0d: valid=%b pc=%h instr=%h expected 1/000/10000000", c, dec_valid, dec_pc, dec_instr);
                end
                checks++;
                if (imem_req !== 1'b0 || imem_addr !== 12'h002) begin
                    errors++;
                    $display("FAIL stall_req c%0d: req=%b addr=%h expected 0/002", c, imem_req, imem_addr);
                end
            end
            next_cycle();
        end
        dec_ready = 1'b1;
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL stall_drain: %0d left expected 0", q_exp.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) push_exp(12'(i));
        for (int c = 0; c < 12; c++) begin
            redirect_valid = (c == 5);
            redirect_pc    = 12'h100;
            if (c == 5) for (int i = 0; i < 4; i++) push_exp(12'h100 + 12'(i));
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                checks++;
                if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid c%0d: got %b expected 0", c, dec_valid); end
            end
            if (c == 6) begin
                checks++;
                if (imem_addr !== 12'h100 || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL redir_addr: addr=%h req=%b expected 100/1", imem_addr, imem_req);
                end
            end
            if (c == 8) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== 12'h100) begin
                    errors++;
                    $display("FAIL redir_first: valid=%b pc=%h expected 1/100", dec_valid, dec_pc);
                end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL redir_drain: %0d left expected 0", q_exp.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        push_exp(12'hFFE);
        push_exp(12'hFFF);
        push_exp(12'h000);
        push_exp(12'h001);
        for (int c = 0; c < 7; c++) begin
            redirect_valid = (c == 0);
            redirect_pc    = 12'hFFE;
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_redir: valid=%b req=%b expected 0/0", dec_valid, imem_req);
                end
            end
            if (c == 1) begin
                checks++;
                if (imem_addr !== 12'hFFE) begin errors++; $display("FAIL wrap_target: got %h expected ffe", imem_addr); end
            end
            if (c == 3) begin
                checks++;
                if (imem_addr !== 12'h000) begin errors++; $display("FAIL wrap_roll: got %h expected 000", imem_addr); end
            end
            next_cycle();
        end
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left expected 0", q_exp.size()); end
    endtask

    task automatic test_full_redirect();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            dec_ready      = (c >= 4);
            redirect_valid = (c == 4);
            redirect_pc    = 12'h040;
            if (c == 4) begin
                push_exp(12'h040);
                push_exp(12'h041);
            end
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (dec_valid !== 1'b1 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL full_state: valid=%b req=%b expected 1/0", dec_valid, imem_req);
                end
            end
            if (c == 4 || c == 6) begin
                checks++;
                if (dec_valid !== 1'b0) begin errors++; $display("FAIL full_flush c%0d: got %b expected 0", c, dec_valid); end
            end
            if (c == 5) begin
                checks++;
                if (dec_valid !== 1'b0 || imem_addr !== 12'h040 || imem_req !== 1'b1) begin
                    errors++;
                    $display("FAIL full_resume: valid=%b addr=%h req=%b expected 0/040/1", dec_valid, imem_addr, imem_req);
                end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL full_drain: %0d left expected 0", q_exp.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_exp(12'h000);
        push_exp(12'h001);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            next_cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 12'h0 || dec_pc !== 12'h0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%b req=%b addr=%h pc=%h expected 0/0/000/000", dec_valid, imem_req, imem_addr, dec_pc);
        end
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL arst_pre_drain: %0d left expected 0", q_exp.size()); end
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(12'(i));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (imem_addr !== c[AW-1:0] || dec_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL arst_restream c%0d: addr=%h valid=%b expected %h/%b", c, imem_addr, dec_valid, c[AW-1:0], (c >= 2));
            end
            next_cycle();
        end
        checks++;
        if (q_exp.size() != 0) begin errors++; $display("FAIL arst_drain: %0d left expected 0", q_exp.size()); end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_full_redirect();
        test_async_reset();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
